// File: rtl/find_first_one_pkg.sv
// Shared constants for the find_first_one block: default operand and chunk widths and the
// controller state encoding. Imported by the RTL and by the testbench so both agree on
// the same defaults.
package find_first_one_pkg;

  localparam int unsigned DefWidth = 1024;
  localparam int unsigned DefChunk = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/find_first_one_if.sv
// Operand/result handshake bundle for find_first_one.
//   in_valid/in_ready/A          : operand channel (producer -> block)
//   out_valid/out_ready/index/zero: result channel (block -> consumer)
// master: producer/consumer side; slave: the search block.
interface find_first_one_if #(
  parameter int unsigned WIDTH = find_first_one_pkg::DefWidth
) ();

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic             out_valid;
  logic             out_ready;
  logic [IdxW-1:0]  index;
  logic             zero;

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    input  out_valid,
    output out_ready,
    input  index,
    input  zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    output out_valid,
    input  out_ready,
    output index,
    output zero
  );

endinterface

// File: rtl/find_first_one_chunk_lead_one.sv
// chunk_lead_one: combinational highest-set-bit finder for one chunk.
//   d   : CHUNK-bit chunk to examine
//   any : at least one bit of d is set
//   pos : position of the highest set bit of d (0 when d is zero)
module chunk_lead_one #(
  parameter int unsigned CHUNK = find_first_one_pkg::DefChunk,
  localparam int unsigned PosW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] d,
  output logic             any,
  output logic [PosW-1:0]  pos
);

  // Ascending scan: the last hit seen is the highest set bit.
  always_comb begin
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (d[i]) begin
        any = 1'b1;
        pos = PosW'(i);
      end
    end
  end

endmodule

// File: rtl/find_first_one.sv
// find_first_one: multi-cycle leading-one search over a WIDTH-bit operand, CHUNK bits per cycle,
// starting at the most significant chunk.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : find_first_one_if.slave (operand in, index/zero result out)
// Latency from the accepting edge to out_valid equals the number of chunks examined.
module find_first_one
  import find_first_one_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input logic             clk,
  input logic             rst,
  find_first_one_if.slave bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned PtrW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned IdxW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PosW      = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumChunks - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [PtrW-1:0]  ptr_q;
  logic [IdxW-1:0]  index_q;
  logic             zero_q;

  logic [CHUNK-1:0] chunk;
  logic             chunk_any;
  logic [PosW-1:0]  chunk_pos;
  logic [IdxW-1:0]  hit_index;

  // Only the registered operand is searched, so A may change freely once accepted.
  assign chunk = a_q[ptr_q*CHUNK +: CHUNK];

  chunk_lead_one #(
    .CHUNK(CHUNK)
  ) u_lead (
    .d  (chunk),
    .any(chunk_any),
    .pos(chunk_pos)
  );

  assign hit_index = IdxW'(ptr_q) * IdxW'(CHUNK) + IdxW'(chunk_pos);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      ptr_q   <= LastPtr;
      index_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            ptr_q   <= LastPtr;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (chunk_any) begin
            index_q <= hit_index;
            zero_q  <= 1'b0;
            state_q <= StDone;
          end else if (ptr_q == '0) begin
            index_q <= '0;
            zero_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            ptr_q <= ptr_q - 1'b1;
          end
        end
        StDone: begin
          // Return to idle only; a new operand is taken on a later edge.
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.index     = index_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_find_first_one.sv
// Directed testbench for find_first_one at default parameters.
module tb_find_first_one;
  import find_first_one_pkg::*;

  localparam int unsigned W    = DefWidth;
  localparam int unsigned C    = DefChunk;
  localparam int unsigned IdxW = $clog2(W);
  localparam int          MaxWait = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  find_first_one_if #(.WIDTH(W)) bus ();

  find_first_one #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand for exactly one accepting edge.
  task automatic accept(input logic [W-1:0] a);
    bus.A        = a;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Count cycles after the accepting edge until out_valid; MaxWait on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < MaxWait) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.index !== '0 || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_result got index=%0d zero=%b want 0 0", bus.index, bus.zero);
    end
  endtask

  task automatic test_all_zero();
    int lat;
    accept('0);
    wait_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL zero_latency got=%0d want=16", lat);
    end
    checks++;
    if (bus.zero !== 1'b1 || bus.index !== IdxW'(0)) begin
      failures++;
      $display("FAIL zero_result got index=%0d zero=%b want 0 1", bus.index, bus.zero);
    end
    release_result();
  endtask

  task automatic test_msb();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[1023] = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL msb_latency got=%0d want=1", lat);
    end
    checks++;
    if (bus.index !== IdxW'(1023) || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL msb_result got index=%0d zero=%b want 1023 0", bus.index, bus.zero);
    end
    release_result();
  endtask

  task automatic test_lsb();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[0] = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL lsb_latency got=%0d want=16", lat);
    end
    checks++;
    if (bus.index !== IdxW'(0) || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL lsb_result got index=%0d zero=%b want 0 0", bus.index, bus.zero);
    end
    release_result();
  endtask

  task automatic test_two_bits();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[700] = 1'b1;
    op[5]   = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL two_bits_latency got=%0d want=6", lat);
    end
    checks++;
    if (bus.index !== IdxW'(700) || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL two_bits_result got index=%0d zero=%b want 700 0", bus.index, bus.zero);
    end
    release_result();
  endtask

  // Hold the result under backpressure while a stray operand is offered.
  task automatic test_backpressure();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[129] = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=14", lat);
    end
    bus.A        = '1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.index !== IdxW'(129) ||
          bus.zero !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got out_valid=%b in_ready=%b index=%0d zero=%b want 1 0 129 0",
                 i, bus.out_valid, bus.in_ready, bus.index, bus.zero);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept got in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    logic [W-1:0] op;
    accept('0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.index !== IdxW'(0)) begin
      failures++;
      $display("FAIL rst_scan got in_ready=%b out_valid=%b index=%0d want 1 0 0",
               bus.in_ready, bus.out_valid, bus.index);
    end
    op = '0;
    op[64] = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (lat !== 15) begin
      failures++;
      $display("FAIL rst_scan_next_latency got=%0d want=15", lat);
    end
    checks++;
    if (bus.index !== IdxW'(64) || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_scan_next_result got index=%0d zero=%b want 64 0", bus.index, bus.zero);
    end
    release_result();
  endtask

  // Reset in DONE with both handshakes active: reset wins, nothing is accepted.
  task automatic test_reset_in_done();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[1000] = 1'b1;
    accept(op);
    wait_valid(lat);
    checks++;
    if (bus.index !== IdxW'(1000)) begin
      failures++;
      $display("FAIL rst_done_pre got index=%0d want 1000", bus.index);
    end
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.index !== IdxW'(0) ||
        bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got in_ready=%b out_valid=%b index=%0d zero=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.index, bus.zero);
    end
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_done_idle got in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_input_change();
    int lat;
    logic [W-1:0] op;
    op = '0;
    op[3] = 1'b1;
    accept(op);
    bus.A = '1;
    wait_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL hold_a_latency got=%0d want=16", lat);
    end
    checks++;
    if (bus.index !== IdxW'(3) || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL hold_a_result got index=%0d zero=%b want 3 0", bus.index, bus.zero);
    end
    release_result();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    test_reset();
    test_all_zero();
    test_msb();
    test_lsb();
    test_two_bits();
    test_backpressure();
    test_reset_mid_scan();
    test_reset_in_done();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
